// File: rtl/sysbus_arbiter.sv
// Two-client Sysbus master arbiter: round-robin grant, one burst at a time,
// request pass-through from the owner and read beats routed back to it.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif

module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] c0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
    output logic                      c0_reqack,
    output logic                      c0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] c0_resp,
    input  logic                      c1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] c1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
    output logic                      c1_reqack,
    output logic                      c1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] c1_resp,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int CW = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    state_t                    state, state_nx;
    logic                      owner, owner_nx;
    logic                      last_grant, last_grant_nx;
    logic [CW-1:0]             beat, beat_nx;
    logic                      ack, resp_valid;
    logic [BUS_DATA_WIDTH-1:0] sel_req;
    logic [BUS_TAG_WIDTH-1:0]  sel_tag;
    logic                      unused_resptag;

    // Response routing relies on the registered owner, not the returned tag.
    assign unused_resptag = ^bus_resptag;

    assign sel_req = owner ? c1_req : c0_req;
    assign sel_tag = owner ? c1_reqtag : c0_reqtag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            beat       <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_grant_nx;
            beat       <= beat_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        beat_nx       = beat;
        bus_reqcyc    = 1'b0;
        bus_req       = '0;
        bus_reqtag    = '0;
        bus_respack   = 1'b0;
        ack           = 1'b0;
        resp_valid    = 1'b0;
        unique case (state)
            IDLE: begin
                if (c0_reqcyc || c1_reqcyc) begin
                    if (c0_reqcyc && c1_reqcyc)
                        owner_nx = ~last_grant;
                    else
                        owner_nx = c1_reqcyc;
                    last_grant_nx = owner_nx;
                    state_nx      = ADDR;
                end
            end
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = sel_req;
                bus_reqtag = sel_tag;
                ack        = bus_reqack;
                if (bus_reqack) begin
                    beat_nx  = '0;
                    state_nx = (sel_tag[12] == `SYSBUS_READ) ? RDATA : WDATA;
                end
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = sel_req;
                bus_reqtag = sel_tag;
                ack        = bus_reqack;
                if (bus_reqack) begin
                    if (beat == LAST) begin
                        beat_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        beat_nx = beat + CW'(1);
                    end
                end
            end
            RDATA: begin
                bus_respack = bus_respcyc;
                resp_valid  = bus_respcyc;
                if (bus_respcyc) begin
                    if (beat == LAST) begin
                        beat_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        beat_nx = beat + CW'(1);
                    end
                end
            end
        endcase
    end

    assign c0_reqack  = ack & ~owner;
    assign c1_reqack  = ack & owner;
    assign c0_respcyc = resp_valid & ~owner;
    assign c1_respcyc = resp_valid & owner;
    assign c0_resp    = c0_respcyc ? bus_resp : '0;
    assign c1_resp    = c1_respcyc ? bus_resp : '0;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: stimulus queues expected beats,
// negedge monitors pop and compare whatever the arbiter presents.
module tb_sysbus_arbiter;

    localparam logic [12:0] RD_TAG = 13'h1100;
    localparam logic [12:0] WR_TAG = 13'h0100;

    typedef struct {
        bit          cl;
        logic [63:0] d;
        logic [12:0] t;
    } req_t;

    typedef struct {
        bit          cl;
        logic [63:0] d;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        c0_reqcyc, c1_reqcyc;
    logic [63:0] c0_req, c1_req;
    logic [12:0] c0_reqtag, c1_reqtag;
    logic        c0_reqack, c1_reqack;
    logic        c0_respcyc, c1_respcyc;
    logic [63:0] c0_resp, c1_resp;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;

    int checks = 0;
    int errors = 0;
    int c1_acks = 0;

    req_t  req_q[$];
    resp_t resp_q[$];
    req_t  rq;
    resp_t rs;

    sysbus_arbiter dut (
        .clk(clk), .reset(reset),
        .c0_reqcyc(c0_reqcyc), .c0_req(c0_req), .c0_reqtag(c0_reqtag),
        .c0_reqack(c0_reqack), .c0_respcyc(c0_respcyc), .c0_resp(c0_resp),
        .c1_reqcyc(c1_reqcyc), .c1_req(c1_req), .c1_reqtag(c1_reqtag),
        .c1_reqack(c1_reqack), .c1_respcyc(c1_respcyc), .c1_resp(c1_resp),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Request-side monitor: every accepted beat must match the queue head.
    always @(negedge clk) begin
        if (reset) begin
            if (c1_reqack) c1_acks++;
            if (bus_reqcyc && bus_reqack) begin
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_beat: unexpected beat bus_req=%h", bus_req);
                end else begin
                    rq = req_q.pop_front();
                    if (bus_req !== rq.d || bus_reqtag !== rq.t ||
                        {c0_reqack, c1_reqack} !== (rq.cl ? 2'b01 : 2'b10)) begin
                        errors++;
                        $display("FAIL req_beat: got req=%h tag=%h acks=%b, want req=%h tag=%h client=%0d",
                                 bus_req, bus_reqtag, {c0_reqack, c1_reqack},
                                 rq.d, rq.t, rq.cl);
                    end
                end
            end else if (c0_reqack || c1_reqack) begin
                checks++;
                errors++;
                $display("FAIL stray_reqack: acks=%b without bus accept",
                         {c0_reqack, c1_reqack});
            end
        end
    end

    // Response-side monitor.
    always @(negedge clk) begin
        if (c0_respcyc || c1_respcyc) begin
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_beat: unexpected respcyc=%b", {c0_respcyc, c1_respcyc});
            end else begin
                rs = resp_q.pop_front();
                if ({c0_respcyc, c1_respcyc} !== (rs.cl ? 2'b01 : 2'b10) ||
                    (rs.cl ? c1_resp : c0_resp) !== rs.d || bus_respack !== 1'b1) begin
                    errors++;
                    $display("FAIL resp_beat: got respcyc=%b c0=%h c1=%h respack=%b, want client=%0d data=%h",
                             {c0_respcyc, c1_respcyc}, c0_resp, c1_resp,
                             bus_respack, rs.cl, rs.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_ctrl"},
            64'({bus_reqcyc, bus_respack, c0_reqack, c1_reqack, c0_respcyc, c1_respcyc}), 0);
        chk({name, "_bus_req"}, bus_req, 0);
        chk({name, "_bus_reqtag"}, 64'(bus_reqtag), 0);
        chk({name, "_resp"}, c0_resp | c1_resp, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bus();
        int n = 0;
        while (!bus_reqcyc && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!bus_reqcyc) begin
            errors++;
            $display("FAIL wait_bus: bus_reqcyc=0 after %0d cycles, want 1", n);
        end
    endtask

    task automatic addr_phase(input int stall);
        wait_bus();
        repeat (stall) tick();
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
    endtask

    task automatic read_beats(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(i);
            tick();
        end
        bus_respcyc = 1'b0;
        bus_resp    = '0;
    endtask

    task automatic set_client(input bit cl, input logic v,
                              input logic [63:0] a, input logic [12:0] t);
        if (cl) begin
            c1_reqcyc = v; c1_req = a; c1_reqtag = t;
        end else begin
            c0_reqcyc = v; c0_req = a; c0_reqtag = t;
        end
    endtask

    task automatic push_read(input bit cl, input logic [63:0] addr,
                             input logic [63:0] base);
        req_q.push_back('{cl, addr, RD_TAG});
        for (int i = 0; i < 8; i++) resp_q.push_back('{cl, base + 64'(i)});
    endtask

    task automatic do_read(input bit cl, input logic [63:0] addr,
                           input logic [63:0] base, input int stall);
        push_read(cl, addr, base);
        set_client(cl, 1'b1, addr, RD_TAG);
        addr_phase(stall);
        set_client(cl, 1'b0, addr, RD_TAG);
        read_beats(base, 8);
    endtask

    int wr_stall[9] = '{2, 0, 1, 3, 0, 0, 2, 1, 0};

    initial begin
        reset = 1'b0;
        {c0_reqcyc, c1_reqcyc, bus_reqack, bus_respcyc} = '0;
        c0_req = '0; c1_req = '0; c0_reqtag = '0; c1_reqtag = '0;
        bus_resp = '0; bus_resptag = '0;
        #1;
        chk_quiet("reset");

        // Both clients request straight out of reset.
        set_client(0, 1'b1, 64'h100, RD_TAG);
        set_client(1, 1'b1, 64'h200, RD_TAG);
        push_read(0, 64'h100, 64'h1100);
        push_read(1, 64'h200, 64'h1200);
        push_read(0, 64'h100, 64'h1300);
        push_read(1, 64'h200, 64'h1400);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_phase(1);
            if (k == 3) begin
                c0_reqcyc = 1'b0;
                c1_reqcyc = 1'b0;
            end
            read_beats(64'h1100 + 64'(k) * 64'h100, 8);
        end
        tick();
        chk("rr_idle_after", 64'(bus_reqcyc), 0);
        chk("rr_queue_empty", 64'(req_q.size() + resp_q.size()), 0);

        do_read(0, 64'h1000, 64'hA0, 2);
        tick();
        chk("read_idle_after", 64'(bus_reqcyc), 0);
        chk("read_queue_empty", 64'(resp_q.size()), 0);

        // Write burst from client 1 with a stalled bus.
        c1_acks = 0;
        req_q.push_back('{1'b1, 64'h2000, WR_TAG});
        for (int i = 0; i < 8; i++) req_q.push_back('{1'b1, 64'hD0 + 64'(i), WR_TAG});
        set_client(1, 1'b1, 64'h2000, WR_TAG);
        wait_bus();
        for (int i = 0; i < 9; i++) begin
            c1_req = (i == 0) ? 64'h2000 : 64'hCF + 64'(i);
            repeat (wr_stall[i]) tick();
            bus_reqack = 1'b1;
            tick();
            bus_reqack = 1'b0;
        end
        c1_reqcyc = 1'b0;
        tick();
        chk("write_acks", 64'(c1_acks), 9);
        chk("write_idle_after", 64'(bus_reqcyc), 0);
        chk("write_queue_empty", 64'(req_q.size()), 0);

        // Stray response while idle.
        bus_respcyc = 1'b1;
        bus_resp    = 64'hEE;
        repeat (3) begin
            tick();
            chk_quiet("stray");
        end
        bus_respcyc = 1'b0;
        bus_resp    = '0;

        // Client 1 asks during client 0's final read beat.
        push_read(0, 64'h3000, 64'h3100);
        set_client(0, 1'b1, 64'h3000, RD_TAG);
        addr_phase(0);
        c0_reqcyc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'h3100 + 64'(i);
            if (i == 7) begin
                set_client(1, 1'b1, 64'h4000, RD_TAG);
                push_read(1, 64'h4000, 64'h4100);
            end
            tick();
        end
        bus_respcyc = 1'b0;
        chk("lastbeat_idle_gap", 64'(bus_reqcyc), 0);
        tick();
        chk("lastbeat_addr", 64'(bus_reqcyc), 1);
        chk("lastbeat_addr_req", bus_req, 64'h4000);
        addr_phase(0);
        c1_reqcyc = 1'b0;
        read_beats(64'h4100, 8);

        // Reset mid-read after four beats.
        req_q.push_back('{1'b0, 64'h5000, RD_TAG});
        for (int i = 0; i < 4; i++) resp_q.push_back('{1'b0, 64'h5100 + 64'(i)});
        set_client(0, 1'b1, 64'h5000, RD_TAG);
        addr_phase(1);
        read_beats(64'h5100, 4);
        bus_respcyc = 1'b1;
        bus_resp    = 64'h5104;
        #3;
        reset = 1'b0;
        #1;
        chk_quiet("midreset");
        c0_reqcyc   = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        tick();
        reset = 1'b1;
        chk("midreset_queue_empty", 64'(resp_q.size()), 0);
        do_read(1, 64'h6000, 64'h6100, 1);
        tick();
        chk("final_idle", 64'(bus_reqcyc), 0);
        chk("final_queue_empty", 64'(req_q.size() + resp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
